// File: rtl/dvi_timing_sequencer.sv
// dvi_timing_sequencer
// Video timing generator and frame sequencer for the DVI output path.
// Generates hsync/vsync/den in the pixel clock domain and consumes pixels
// from the upstream pixel source. Frames start and stop only on frame
// boundaries. A missing pixel during active video sets a sticky underflow flag.
//
// Ports:
//   clk            in   pixel clock
//   rst_n          in   asynchronous active-low reset
//   en             in   run request, sampled every cycle
//   rgb_vld        in   upstream has a pixel available
//   underflow_clr  in   one-cycle pulse, clears underflow
//   rgb_rdy        out  pixel consumed this cycle (copy of den)
//   den            out  active video
//   hsync          out  horizontal sync, polarity set by H_SYNC_POLARITY
//   vsync          out  vertical sync, polarity set by V_SYNC_POLARITY
//   frame_start    out  one-cycle pulse on the first cycle of each frame
//   busy           out  a frame is in progress
//   underflow      out  sticky: den was high while rgb_vld was low
module dvi_timing_sequencer #(
   parameter bit          H_SYNC_POLARITY = 1'b0,
   parameter int unsigned H_FRONT_PORCH   = 16,
   parameter int unsigned H_SYNC_WIDTH    = 96,
   parameter int unsigned H_BACK_PORCH    = 48,
   parameter int unsigned H_ACTIVE_PIXELS = 640,
   parameter bit          V_SYNC_POLARITY = 1'b0,
   parameter int unsigned V_FRONT_PORCH   = 10,
   parameter int unsigned V_SYNC_WIDTH    = 2,
   parameter int unsigned V_BACK_PORCH    = 33,
   parameter int unsigned V_ACTIVE_LINES  = 480
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic rgb_vld,
   input  logic underflow_clr,
   output logic rgb_rdy,
   output logic den,
   output logic hsync,
   output logic vsync,
   output logic frame_start,
   output logic busy,
   output logic underflow
);

   // Counter widths come from the longest phase in each direction.
   localparam int unsigned H_MAX_A = (H_FRONT_PORCH > H_SYNC_WIDTH) ? H_FRONT_PORCH : H_SYNC_WIDTH;
   localparam int unsigned H_MAX_B = (H_BACK_PORCH > H_ACTIVE_PIXELS) ? H_BACK_PORCH
                                                                      : H_ACTIVE_PIXELS;
   localparam int unsigned H_MAX   = (H_MAX_A > H_MAX_B) ? H_MAX_A : H_MAX_B;
   localparam int unsigned V_MAX_A = (V_FRONT_PORCH > V_SYNC_WIDTH) ? V_FRONT_PORCH : V_SYNC_WIDTH;
   localparam int unsigned V_MAX_B = (V_BACK_PORCH > V_ACTIVE_LINES) ? V_BACK_PORCH
                                                                     : V_ACTIVE_LINES;
   localparam int unsigned V_MAX   = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
   localparam int unsigned HW      = (H_MAX > 1) ? $clog2(H_MAX) : 1;
   localparam int unsigned VW      = (V_MAX > 1) ? $clog2(V_MAX) : 1;

   if (H_FRONT_PORCH == 0 || H_SYNC_WIDTH == 0 || H_BACK_PORCH == 0 || H_ACTIVE_PIXELS == 0 ||
       V_FRONT_PORCH == 0 || V_SYNC_WIDTH == 0 || V_BACK_PORCH == 0 || V_ACTIVE_LINES == 0)
   begin : g_bad_length
      $error("dvi_timing_sequencer: every timing length must be >= 1");
   end

   typedef enum logic [2:0] {StIdle, StSync, StBack, StActive, StFront} state_e;

   state_e          h_state_q, h_state_d;
   state_e          v_state_q, v_state_d;
   logic [HW-1:0]   h_cnt_q, h_cnt_d;
   logic [VW-1:0]   v_cnt_q, v_cnt_d;
   logic            start;
   logic            h_last;
   logic            frame_end;

   logic den_q, hsync_q, vsync_q, frame_start_q, busy_q, underflow_q;

   // Running phases only; IDLE is left through the start path, never through here.
   function automatic state_e next_phase(input state_e s);
      unique case (s)
         StSync:   return StBack;
         StBack:   return StActive;
         StActive: return StFront;
         default:  return StSync;
      endcase
   endfunction

   function automatic logic [HW-1:0] h_load(input state_e s);
      unique case (s)
         StSync:   return HW'(H_SYNC_WIDTH - 1);
         StBack:   return HW'(H_BACK_PORCH - 1);
         StActive: return HW'(H_ACTIVE_PIXELS - 1);
         StFront:  return HW'(H_FRONT_PORCH - 1);
         default:  return '0;
      endcase
   endfunction

   function automatic logic [VW-1:0] v_load(input state_e s);
      unique case (s)
         StSync:   return VW'(V_SYNC_WIDTH - 1);
         StBack:   return VW'(V_BACK_PORCH - 1);
         StActive: return VW'(V_ACTIVE_LINES - 1);
         StFront:  return VW'(V_FRONT_PORCH - 1);
         default:  return '0;
      endcase
   endfunction

   always_comb begin
      h_state_d = h_state_q;
      h_cnt_d   = h_cnt_q;
      v_state_d = v_state_q;
      v_cnt_d   = v_cnt_q;
      start     = 1'b0;
      h_last    = (h_state_q == StFront) && (h_cnt_q == '0);
      frame_end = h_last && (v_state_q == StFront) && (v_cnt_q == '0);

      if (h_state_q == StIdle || frame_end) begin
         // Frame boundary: either launch a new frame or park in IDLE.
         if (en) begin
            start     = 1'b1;
            h_state_d = StSync;
            h_cnt_d   = h_load(StSync);
            v_state_d = StSync;
            v_cnt_d   = v_load(StSync);
         end else begin
            h_state_d = StIdle;
            h_cnt_d   = '0;
            v_state_d = StIdle;
            v_cnt_d   = '0;
         end
      end else begin
         if (h_cnt_q == '0) begin
            h_state_d = next_phase(h_state_q);
            h_cnt_d   = h_load(h_state_d);
         end else begin
            h_cnt_d = h_cnt_q - 1'b1;
         end
         // Vertical timing advances once per line, on its final cycle.
         if (h_last) begin
            if (v_cnt_q == '0) begin
               v_state_d = next_phase(v_state_q);
               v_cnt_d   = v_load(v_state_d);
            end else begin
               v_cnt_d = v_cnt_q - 1'b1;
            end
         end
      end
   end

   // Outputs are registered from the next state so they line up with the FSM state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_state_q     <= StIdle;
         v_state_q     <= StIdle;
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         den_q         <= 1'b0;
         hsync_q       <= ~H_SYNC_POLARITY;
         vsync_q       <= ~V_SYNC_POLARITY;
         frame_start_q <= 1'b0;
         busy_q        <= 1'b0;
         underflow_q   <= 1'b0;
      end else begin
         h_state_q     <= h_state_d;
         v_state_q     <= v_state_d;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         den_q         <= (h_state_d == StActive) && (v_state_d == StActive);
         hsync_q       <= (h_state_d == StSync) ? H_SYNC_POLARITY : ~H_SYNC_POLARITY;
         vsync_q       <= (v_state_d == StSync) ? V_SYNC_POLARITY : ~V_SYNC_POLARITY;
         frame_start_q <= start;
         busy_q        <= (h_state_d != StIdle);
         // A new underflow takes priority over a clear in the same cycle.
         if (den_q && !rgb_vld) begin
            underflow_q <= 1'b1;
         end else if (underflow_clr) begin
            underflow_q <= 1'b0;
         end
      end
   end

   assign den         = den_q;
   assign rgb_rdy     = den_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign frame_start = frame_start_q;
   assign busy        = busy_q;
   assign underflow   = underflow_q;

endmodule

// File: tb/tb_dvi_timing_sequencer.sv
// Bench for dvi_timing_sequencer with H 2/3/4/1 and V 1/2/3/1, active-low syncs:
// 10-cycle lines, 70-cycle frames. Frame cycle 0 is the frame_start cycle.
module tb_dvi_timing_sequencer;

   logic clk = 1'b0;
   logic rst_n, en, rgb_vld, underflow_clr;
   logic rgb_rdy, den, hsync, vsync, frame_start, busy, underflow;

   int n_checks = 0;
   int n_pass   = 0;
   int fc;

   always #5 clk = ~clk;

   dvi_timing_sequencer #(
      .H_SYNC_POLARITY (1'b0),
      .H_FRONT_PORCH   (1),
      .H_SYNC_WIDTH    (2),
      .H_BACK_PORCH    (3),
      .H_ACTIVE_PIXELS (4),
      .V_SYNC_POLARITY (1'b0),
      .V_FRONT_PORCH   (1),
      .V_SYNC_WIDTH    (1),
      .V_BACK_PORCH    (2),
      .V_ACTIVE_LINES  (3)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .en            (en),
      .rgb_vld       (rgb_vld),
      .underflow_clr (underflow_clr),
      .rgb_rdy       (rgb_rdy),
      .den           (den),
      .hsync         (hsync),
      .vsync         (vsync),
      .frame_start   (frame_start),
      .busy          (busy),
      .underflow     (underflow)
   );

   typedef struct {
      int   fc;
      logic den;
      logic hsync;
      logic vsync;
      logic fs;
      logic busy;
   } vec_t;

   vec_t tbl [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic check_outs(input string tag, input logic e_den, input logic e_hs,
                             input logic e_vs, input logic e_fs, input logic e_busy,
                             input logic e_uf);
      check({tag, " den"}, 32'(den), 32'(e_den));
      check({tag, " rgb_rdy"}, 32'(rgb_rdy), 32'(e_den));
      check({tag, " hsync"}, 32'(hsync), 32'(e_hs));
      check({tag, " vsync"}, 32'(vsync), 32'(e_vs));
      check({tag, " frame_start"}, 32'(frame_start), 32'(e_fs));
      check({tag, " busy"}, 32'(busy), 32'(e_busy));
      check({tag, " underflow"}, 32'(underflow), 32'(e_uf));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      fc++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int den_cnt, first_den, hs_lo, vs_lo, fs_cnt, busy_lo, rdy_bad, uf_seen;

      //            fc  den  hs   vs   fs   busy
      tbl[0]  = '{ 0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[1]  = '{ 1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[2]  = '{ 2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[3]  = '{ 9,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[4]  = '{10,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[5]  = '{29,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[6]  = '{34,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[7]  = '{35,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[8]  = '{38,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[9]  = '{39,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[10] = '{55,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[11] = '{60,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[12] = '{69,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

      // Reset held with en high: idle outputs, syncs inactive (high).
      rst_n = 1'b0;
      en = 1'b1;
      rgb_vld = 1'b1;
      underflow_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_outs("reset", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      // Free run for two full frames plus the first cycle of the third.
      @(negedge clk);
      rst_n = 1'b1;
      fc = -1;
      den_cnt = 0; first_den = -1; hs_lo = 0; vs_lo = 0; fs_cnt = 0;
      busy_lo = 0; rdy_bad = 0; uf_seen = 0;
      for (int c = 0; c <= 140; c++) begin
         int fm;
         tick();
         fm = fc % 70;
         foreach (tbl[i]) begin
            if (tbl[i].fc == fm)
               check_outs($sformatf("run fc%0d", fc), tbl[i].den, tbl[i].hsync, tbl[i].vsync,
                          tbl[i].fs, tbl[i].busy, 1'b0);
         end
         if (den) begin
            den_cnt++;
            if (first_den < 0) first_den = fm;
         end
         if (!hsync) hs_lo++;
         if (!vsync) vs_lo++;
         if (frame_start) fs_cnt++;
         if (!busy) busy_lo++;
         if (rgb_rdy !== den) rdy_bad++;
         if (underflow) uf_seen++;
         if (fm == 69) begin
            check($sformatf("frame%0d den count", fc / 70), den_cnt, 12);
            check($sformatf("frame%0d first den", fc / 70), first_den, 35);
            check($sformatf("frame%0d hsync low cycles", fc / 70), hs_lo, 14);
            check($sformatf("frame%0d vsync low cycles", fc / 70), vs_lo, 10);
            check($sformatf("frame%0d frame_start count", fc / 70), fs_cnt, 1);
            den_cnt = 0; first_den = -1; hs_lo = 0; vs_lo = 0; fs_cnt = 0;
         end
      end
      check("run busy low cycles", busy_lo, 0);
      check("run rgb_rdy differs from den", rdy_bad, 0);
      check("run underflow cycles", uf_seen, 0);

      // Stop: en dropped at frame cycle 20, frame completes, then idles.
      fc = 0;
      while (fc < 20) tick();
      en = 1'b0;
      while (fc < 69) tick();
      check_outs("stop fc69", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      check_outs("stop fc70", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) tick();
      check_outs("stop idle", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      en = 1'b1;
      tick();
      check_outs("restart", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      fc = 0;

      // A one-cycle en drop mid-frame must not disturb the frame.
      while (fc < 3) tick();
      en = 1'b0;
      tick();
      en = 1'b1;

      // Underflow set, clear, and set-wins-over-clear.
      while (fc < 35) tick();
      check_outs("uf fc35", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      rgb_vld = 1'b0;
      tick();
      check("uf set", 32'(underflow), 32'd1);
      rgb_vld = 1'b1;
      underflow_clr = 1'b1;
      tick();
      check("uf cleared", 32'(underflow), 32'd0);
      rgb_vld = 1'b0;
      tick();
      check("uf set wins over clear", 32'(underflow), 32'd1);
      check("uf no stall den fc38", 32'(den), 32'd1);
      rgb_vld = 1'b1;
      tick();
      check("uf cleared again", 32'(underflow), 32'd0);
      check("uf no stall den fc39", 32'(den), 32'd0);
      underflow_clr = 1'b0;
      rgb_vld = 1'b0;
      tick();
      check("uf no set outside den", 32'(underflow), 32'd0);
      rgb_vld = 1'b1;

      // Reset in the middle of an active line, with underflow pending.
      while (fc < 45) tick();
      rgb_vld = 1'b0;
      tick();
      check_outs("pre-reset fc46", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      rgb_vld = 1'b1;
      #3;
      rst_n = 1'b0;
      #1;
      check_outs("mid reset", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      fc = -1;
      tick();
      check_outs("post reset fc0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      check_outs("post reset fc1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
